// File: rtl/multi_decade_down_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multi_decade_down_counter_pkg                                   |
// | Purpose  : Shared BCD digit width, maximum digit value, digit type and the |
// |            preset clamp used by the three-decade down-counter.             |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package multi_decade_down_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Any non-BCD code (10..15) is forced to 9 so the counter only ever holds
  // legal decimal digits.
  function automatic bcd_digit_t clamp_bcd(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_decade_down_counter_digit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_down_digit                                                  |
// | Purpose  : One BCD decade that loads a digit or decrements with 0->9 wrap. |
// | Ports    : clk, reset_n (async active-low), load, d (load value),          |
// |            enable (decrement), Q (current digit), is_zero (Q == 0)         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bcd_down_digit
  import multi_decade_down_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  bcd_digit_t d,
  input  logic       enable,
  output bcd_digit_t Q,
  output logic       is_zero
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = d;
    end else if (enable) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign Q       = digit_q;
  assign is_zero = (digit_q == '0);

endmodule
`default_nettype wire

// File: rtl/multi_decade_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multi_decade_down_counter                                       |
// | Purpose  : Loadable three-decade BCD down-counter with expiry pulse,       |
// |            optional auto-reload of the stored preset, and cascade borrow.  |
// | Ports    : clk, reset_n (async active-low), load, load_ones/tens/hundreds |
// |            (preset digits), enable (count request), ones/tens/hundreds    |
// |            (count), zero, borrow_out (comb), done, busy (registered)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module multi_decade_down_counter
  import multi_decade_down_counter_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [BCD_W-1:0] load_ones,
  input  logic [BCD_W-1:0] load_tens,
  input  logic [BCD_W-1:0] load_hundreds,
  input  logic             enable,
  output logic [BCD_W-1:0] ones,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] hundreds,
  output logic             zero,
  output logic             borrow_out,
  output logic             done,
  output logic             busy
);

  // Index 0 = ones, 1 = tens, 2 = hundreds.
  bcd_digit_t [2:0] load_val;
  bcd_digit_t [2:0] preset_q;
  bcd_digit_t [2:0] preset_d;
  bcd_digit_t [2:0] digit_q;
  bcd_digit_t [2:0] digit_load_val;
  logic       [2:0] stage_en;
  logic       [2:0] stage_zero;
  logic             digit_load;
  logic             count_is_one;
  logic             expire;
  logic             reload;
  logic             done_q;
  logic             done_d;
  logic             busy_q;
  logic             busy_d;

  assign load_val = {clamp_bcd(load_hundreds), clamp_bcd(load_tens), clamp_bcd(load_ones)};

  assign zero         = &stage_zero;
  assign borrow_out   = enable & zero;
  assign count_is_one = (digit_q[0] == 4'd1) & stage_zero[1] & stage_zero[2];
  assign expire       = enable & ~load & count_is_one;
  assign reload       = expire & AUTO_RELOAD;

  // Reload reuses the digits' load path so the 001 -> preset step is a single
  // edge; an external load always takes precedence over the stored preset.
  assign digit_load     = load | reload;
  assign digit_load_val = load ? load_val : preset_q;

  // Decrement chain is gated at 000 so the counter parks instead of wrapping.
  assign stage_en[0] = enable & ~zero;
  assign stage_en[1] = enable & ~zero & stage_zero[0];
  assign stage_en[2] = enable & ~zero & stage_zero[0] & stage_zero[1];

  for (genvar i = 0; i < 3; i++) begin : g_digit
    bcd_down_digit u_digit (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (digit_load),
      .d       (digit_load_val[i]),
      .enable  (stage_en[i]),
      .Q       (digit_q[i]),
      .is_zero (stage_zero[i])
    );
  end

  always_comb begin
    preset_d = preset_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    if (load) begin
      preset_d = load_val;
      busy_d   = (load_val != '0);
    end else if (expire) begin
      done_d = 1'b1;
      busy_d = reload;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      preset_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      preset_q <= preset_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign ones     = digit_q[0];
  assign tens     = digit_q[1];
  assign hundreds = digit_q[2];
  assign done     = done_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_decade_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_multi_decade_down_counter                                    |
// | Purpose  : Scoreboard bench for the three-decade down-counter, driving a   |
// |            plain and an auto-reload instance from the same stimulus.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_multi_decade_down_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [3:0] load_ones, load_tens, load_hundreds;
  logic       enable;

  logic [3:0] ones0, tens0, hundreds0, ones1, tens1, hundreds1;
  logic       zero0, borrow0, done0, busy0;
  logic       zero1, borrow1, done1, busy1;

  always #5 clk = ~clk;

  multi_decade_down_counter #(.AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .load(load),
    .load_ones(load_ones), .load_tens(load_tens), .load_hundreds(load_hundreds),
    .enable(enable), .ones(ones0), .tens(tens0), .hundreds(hundreds0),
    .zero(zero0), .borrow_out(borrow0), .done(done0), .busy(busy0)
  );

  multi_decade_down_counter #(.AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .load(load),
    .load_ones(load_ones), .load_tens(load_tens), .load_hundreds(load_hundreds),
    .enable(enable), .ones(ones1), .tens(tens1), .hundreds(hundreds1),
    .zero(zero1), .borrow_out(borrow1), .done(done1), .busy(busy1)
  );

  typedef struct {
    int v0; bit done0; bit busy0;
    int v1; bit done1; bit busy1;
    bit en;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: the count is held as a plain integer 0..999.
  int m_v[2], m_p[2];
  bit m_done[2], m_busy[2];

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int clampd(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  function automatic void model_step(input int k, input bit ar, input bit ld,
                                     input int h, input int t, input int o, input bit en);
    m_done[k] = 1'b0;
    if (ld) begin
      m_p[k]    = 100 * clampd(h) + 10 * clampd(t) + clampd(o);
      m_v[k]    = m_p[k];
      m_busy[k] = (m_v[k] != 0);
    end else if (en && m_v[k] != 0) begin
      if (m_v[k] == 1) begin
        m_done[k] = 1'b1;
        if (ar) begin
          m_v[k]    = m_p[k];
          m_busy[k] = 1'b1;
        end else begin
          m_v[k]    = 0;
          m_busy[k] = 1'b0;
        end
      end else begin
        m_v[k] = m_v[k] - 1;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0; m_p[k] = 0; m_done[k] = 1'b0; m_busy[k] = 1'b0;
    end
  endfunction

  // One stimulus cycle: drive on the falling edge, predict the post-edge state.
  task automatic drive(input bit ld, input int h, input int t, input int o, input bit en);
    exp_t e;
    @(negedge clk);
    load          = ld;
    load_hundreds = 4'(h);
    load_tens     = 4'(t);
    load_ones     = 4'(o);
    enable        = en;
    model_step(0, 1'b0, ld, h, t, o, en);
    model_step(1, 1'b1, ld, h, t, o, en);
    e.v0 = m_v[0]; e.done0 = m_done[0]; e.busy0 = m_busy[0];
    e.v1 = m_v[1]; e.done1 = m_done[1]; e.busy1 = m_busy[1];
    e.en = en;
    exp_q.push_back(e);
  endtask

  // Monitor: each rising edge presents one predicted state.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("count0",  100 * hundreds0 + 10 * tens0 + ones0, e.v0);
      check("done0",   done0, e.done0);
      check("busy0",   busy0, e.busy0);
      check("zero0",   zero0, e.v0 == 0);
      check("borrow0", borrow0, e.en && e.v0 == 0);
      check("count1",  100 * hundreds1 + 10 * tens1 + ones1, e.v1);
      check("done1",   done1, e.done1);
      check("busy1",   busy1, e.busy1);
      check("zero1",   zero1, e.v1 == 0);
      check("borrow1", borrow1, e.en && e.v1 == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; load = 1'b0; enable = 1'b0;
    load_ones = '0; load_tens = '0; load_hundreds = '0;
    model_reset();
    #1;
    check("rst_count0", 100 * hundreds0 + 10 * tens0 + ones0, 0);
    check("rst_done0", done0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_zero0", zero0, 1);
    check("rst_count1", 100 * hundreds1 + 10 * tens1 + ones1, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 123 counting down across a tens borrow.
    drive(1, 1, 2, 3, 0);
    repeat (4) drive(0, 0, 0, 0, 1);

    // 100 down to 000 and one extra enable while parked.
    drive(1, 1, 0, 0, 0);
    repeat (101) drive(0, 0, 0, 0, 1);

    // 003 with continuous enable: plain parks, auto-reload cycles period 3.
    drive(1, 0, 0, 3, 0);
    repeat (9) drive(0, 0, 0, 0, 1);

    // Illegal digits clamp to 999; loading 000 leaves the counter idle.
    drive(1, 12, 15, 10, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 1);

    // Load wins over an expiry-causing enable at 001.
    drive(1, 0, 0, 3, 0);
    repeat (2) drive(0, 0, 0, 0, 1);
    drive(1, 0, 5, 0, 1);
    drive(0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a cycle at 077.
    drive(1, 0, 7, 7, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    load = 1'b0; enable = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_count0", 100 * hundreds0 + 10 * tens0 + ones0, 0);
    check("async_done0", done0, 0);
    check("async_busy0", busy0, 0);
    check("async_count1", 100 * hundreds1 + 10 * tens1 + ones1, 0);
    check("async_busy1", busy1, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) drive(0, 0, 0, 0, 1);

    // Randomised traffic, biased toward small presets so expiries are common.
    for (int i = 0; i < 800; i++) begin
      bit ld;
      ld = ($urandom_range(0, 19) == 0);
      drive(ld,
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : 0,
            $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : 0,
            $urandom_range(0, 15),
            $urandom_range(0, 3) != 0);
    end
    drive(0, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_decade_down_counter.md
# multi_decade_down_counter

Three-decade BCD down-counter: loadable, with the same ones/tens/hundreds digit format and enable-chained decade structure as the team's up-counting decade counter. It counts a loaded value down to 000, pulses `done` on arrival, and exposes a combinational borrow output so it can cascade with further decades. It sits beside the up-counter in countdown and timer datapaths, for example a preset-and-expire interval timer.

## Interface
- `AUTO_RELOAD`, default 0. When 1, the counter reloads the stored preset instead of reaching 000.

- `clk`  in  1  Single clock; all state changes on its rising edge.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `load`  in  1  Synchronous preset strobe.
- `load_ones`, `load_tens`, `load_hundreds`  in  4 each  BCD preset digits.
- `enable`  in  1  Count-down request for this cycle.
- `ones`, `tens`, `hundreds`  out  4 each  Current count, registered.
- `zero`  out  1  Combinational; 1 when the count is 000.
- `borrow_out`  out  1  Combinational; `enable & zero`, for cascading decades.
- `done`  out  1  Registered one-cycle pulse on expiry.
- `busy`  out  1  Registered; 1 while the count is nonzero.

## Operation
- Reset (async, `reset_n`=0):
  - digits = 000
  - preset register = 000
  - `done` = 0, `busy` = 0
- Priority order: reset > `load` > `enable`.
- Load:
  - Each preset digit > 9 is clamped to 9 before storage, so no illegal BCD code can enter the counter.
  - The clamped value is written to both the digits and the preset register.
  - `busy` = 1 iff the loaded value ≠ 000. `done` = 0 that cycle.
- Enable with count ≠ 000:
  - The ones digit decrements.
  - A digit at 0 that receives a decrement becomes 9 and passes a borrow to the next decade.
  - A digit decrements only when every lower digit is 0 and `enable`=1. This is the down-count mirror of the up-counter's saturation chain.
- Count 001 with `enable`:
  - `AUTO_RELOAD`=0: next count = 000, `done` pulses, `busy` falls.
  - `AUTO_RELOAD`=1: next count = preset, `done` pulses, `busy` stays 1.
- Enable with count 000: the counter holds at 000. `done` does not pulse, and `borrow_out` = 1 for that cycle.
- `enable`=0: all state holds.
- Loading 000: `busy`=0, `done`=0, no expiry.

## Timing
- Digits update one edge after `load` or `enable` is sampled.
- `done` is asserted during the cycle after the expiring edge, for exactly one cycle per expiry.
- `zero` and `borrow_out` have zero latency from the digit registers and `enable`.
- Period in auto-reload with continuous `enable` and preset P: `done` once every P cycles.
- Simultaneous `load` and expiry-causing `enable`: load wins, the count becomes the new preset, and `done` = 0.
- Reset asserted mid-count: outputs clear immediately (asynchronously). Counting resumes only after a new `load`, on the first edge after `reset_n` is high.

## Structure
- Shared package holds:
  - `BCD_W` = 4
  - `BCD_MAX` = 4'd9
  - `bcd_digit_t` (4-bit BCD digit type)
  - a clamp function for preset digits
- One sub-module, `bcd_down_digit`, instantiated three times:
  - Ports: `clk`, `reset_n`, `load`, `d`, `enable`, `Q`, `is_zero`.
  - Decrements with 0→9 wrap.
  - Each stage's enable = previous stage's enable AND previous stage's `is_zero`.
- Top level holds the preset register, expiry detection (count == 001 AND `enable` AND NOT `load`), the `done`/`busy` flops and the reload mux.

## Test plan
- Reset then load 1,2,3 (hundreds,tens,ones); 4 cycles of `enable` → count reads 123, 122, 121, 120, 119; `busy`=1, `done`=0 throughout.
- Load 100, 1 cycle of `enable` → 099; a further 99 enable cycles → 000, `done` high for exactly one cycle, `busy`=0, `zero`=1; a further `enable` → count stays 000, `borrow_out`=1, no `done`.
- `AUTO_RELOAD`=1: load 003, continuous `enable` for 9 cycles → sequence 002, 001, 003, 002, 001, 003, … with `done` on every third cycle; `busy` never falls.
- Load with digits 12, 15, 10 → count reads 999. Load 000 → `busy`=0, no `done` pulse.
- At count 001, assert `load` (value 050) and `enable` together → count 050, `done`=0; at 077, assert `reset_n`=0 mid-cycle → count 000 before the next edge, `done`=0, `busy`=0.
